// File: rtl/ping_pong_ram_if.sv
// Bus bundle for the ping-pong line buffer.
// The master drives the write/read ports and the bank swap; the slave returns read data.
interface ping_pong_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
);
    logic                  line_end;
    logic                  we;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  re;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output line_end, we, write_addr, write_data, re, read_addr,
        input  read_data
    );

    modport slave (
        input  line_end, we, write_addr, write_data, re, read_addr,
        output read_data
    );
endinterface

// File: rtl/ping_pong_ram.sv
// Two-bank line buffer: one bank takes the current line while the other replays
// the previous line, column-aligned. Banks swap on every line_end cycle.
module ping_pong_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048
) (
    input  logic            i_clk,
    input  logic            i_reset,
    ping_pong_ram_if.slave  bus
);
    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    logic                  r_wr_sel;
    logic [DATA_WIDTH-1:0] r_read_data;
    // Bank select is the address MSB so a single array maps onto block RAM.
    logic [DATA_WIDTH-1:0] r_mem [2*DEPTH];

    // Assert immediately, release two edges after reset deasserts.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge i_clk) begin
        if (bus.we) begin
            r_mem[{r_wr_sel, bus.write_addr}] <= bus.write_data;
        end
    end

    // Read and write both use the pre-toggle bank select on a line_end edge.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_sel    <= 1'b0;
            r_read_data <= '0;
        end else begin
            if (bus.line_end) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (bus.re) begin
                r_read_data <= r_mem[{~r_wr_sel, bus.read_addr}];
            end
        end
    end

    assign bus.read_data = r_read_data;
endmodule

// File: tb/tb_ping_pong_ram.sv
// Randomised and directed bench for ping_pong_ram against a two-bank array model.
module tb_ping_pong_ram;
    localparam int DW    = 8;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ping_pong_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ping_pong_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: two banks, a written flag per word, current write bank.
    logic [DW-1:0] m_mem [2][DEPTH];
    bit            m_vld [2][DEPTH];
    int            m_wr;
    logic [DW-1:0] m_rd;
    bit            m_known;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_update();
        if (!rst) begin
            if (bus.we) begin
                m_mem[0][bus.write_addr] = bus.write_data;
                m_vld[0][bus.write_addr] = 1'b1;
            end
            m_wr    = 0;
            m_rd    = '0;
            m_known = 1'b1;
        end else begin
            if (bus.re) begin
                m_known = m_vld[1-m_wr][bus.read_addr];
                m_rd    = m_mem[1-m_wr][bus.read_addr];
            end
            if (bus.we) begin
                m_mem[m_wr][bus.write_addr] = bus.write_data;
                m_vld[m_wr][bus.write_addr] = 1'b1;
            end
            if (bus.line_end) m_wr = 1 - m_wr;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        if (m_known) check_eq(tag, bus.read_data, m_rd);
    endtask

    task automatic idle();
        bus.we       = 1'b0;
        bus.re       = 1'b0;
        bus.line_end = 1'b0;
    endtask

    task automatic pulse_line_end();
        idle();
        bus.line_end = 1'b1;
        step("line_end");
        bus.line_end = 1'b0;
    endtask

    // Writes the four bytes of wdata (MSB first) to addr 1..4 while reading addr 1..4.
    task automatic line_io(input logic [31:0] wdata, input string tag);
        for (int i = 0; i < 4; i++) begin
            bus.we         = 1'b1;
            bus.re         = 1'b1;
            bus.line_end   = 1'b0;
            bus.write_addr = AW'(i + 1);
            bus.read_addr  = AW'(i + 1);
            bus.write_data = wdata[31-8*i -: 8];
            step(tag);
        end
        idle();
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return AW'(DEPTH - 1);
            default: return AW'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic rnd_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.we         = 1'($urandom_range(0, 1));
            bus.re         = 1'($urandom_range(0, 1));
            bus.line_end   = ($urandom_range(0, 15) == 0);
            bus.write_addr = rnd_addr();
            bus.read_addr  = rnd_addr();
            bus.write_data = DW'($urandom);
            step("rand");
        end
        idle();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_wr    = 0;
        m_rd    = '0;
        m_known = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) m_vld[b][a] = 1'b0;

        rst            = 1'b0;
        bus.write_addr = '0;
        bus.read_addr  = '0;
        bus.write_data = '0;
        idle();
        for (int i = 0; i < 3; i++) step("reset_init");
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step("release");

        // Line 0, then lines 1..3 replay the previous line column-aligned.
        line_io(32'hAABBCCDD, "line0");
        pulse_line_end();
        line_io(32'h11223344, "line1");
        check_eq("line1_last", bus.read_data, 8'hDD);
        pulse_line_end();
        line_io(32'h55667788, "line2");
        check_eq("line2_last", bus.read_data, 8'h44);
        pulse_line_end();
        for (int i = 0; i < 4; i++) begin
            bus.re        = 1'b1;
            bus.read_addr = AW'(i + 1);
            step("line3");
        end
        check_eq("line3_last", bus.read_data, 8'h88);

        idle();
        for (int i = 0; i < 5; i++) begin
            bus.read_addr = AW'($urandom_range(0, 7));
            step("hold");
        end
        check_eq("hold_final", bus.read_data, 8'h88);

        // Write coinciding with line_end lands in the outgoing write bank.
        bus.we         = 1'b1;
        bus.line_end   = 1'b1;
        bus.write_addr = AW'(7);
        bus.write_data = 8'h5A;
        step("simul");
        idle();
        bus.re        = 1'b1;
        bus.read_addr = AW'(7);
        step("simul_rd");
        check_eq("simul_5A", bus.read_data, 8'h5A);
        idle();

        rnd_cycles(1500);

        // Reset asserted mid-cycle with traffic active.
        @(posedge clk);
        bus.we = 1'b1;
        bus.re = 1'b1;
        #2;
        rst     = 1'b0;
        m_wr    = 0;
        m_rd    = '0;
        m_known = 1'b1;
        #1;
        check_eq("rst_async", bus.read_data, 8'h00);
        for (int i = 0; i < 4; i++) begin
            bus.write_addr = rnd_addr();
            bus.read_addr  = rnd_addr();
            bus.write_data = DW'($urandom);
            bus.line_end   = 1'($urandom_range(0, 1));
            step("rst_hold");
        end
        idle();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step("rst_release");
        check_eq("rst_release_zero", bus.read_data, 8'h00);

        rnd_cycles(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
